// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter: FSM state
// encoding and the reset value of the instruction buffer.
package mem_arbiter_pkg;

  localparam int MemArbStateBits = 3;

  typedef enum logic [MemArbStateBits-1:0] {
    IDLE  = 3'd0,
    DREQ  = 3'd1,
    DRESP = 3'd2,
    IREQ  = 3'd3,
    IRESP = 3'd4
  } memArbState_e;

  // addi x0, x0, 0 -- the pipeline sees a bubble until the first real fetch
  localparam logic [31:0] NopInstr = 32'h0000_0013;

endpackage

// File: rtl/mem_arbiter_if.sv
// Pipeline-side and memory-side signals of the arbiter. master is the
// arbiter's view; slave is the view of the pipeline plus shared memory.
interface mem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic                  imemReq;
  logic [ADDR_W-1:0]     imemAddr;
  logic [31:0]           imemRdata;
  logic                  dmemRead;
  logic                  dmemWrite;
  logic [ADDR_W-1:0]     dmemAddr;
  logic [DATA_W-1:0]     dmemWdata;
  logic [DATA_W/8-1:0]   dmemBe;
  logic [DATA_W-1:0]     dmemRdata;
  logic                  memValid;
  logic                  memWe;
  logic [ADDR_W-1:0]     memAddr;
  logic [DATA_W-1:0]     memWdata;
  logic [DATA_W/8-1:0]   memBe;
  logic                  memReady;
  logic                  memRespValid;
  logic [DATA_W-1:0]     memRdata;
  logic                  memStall;

  modport master (
    input  imemReq, imemAddr, dmemRead, dmemWrite, dmemAddr, dmemWdata, dmemBe,
    input  memReady, memRespValid, memRdata,
    output imemRdata, dmemRdata, memValid, memWe, memAddr, memWdata, memBe, memStall
  );

  modport slave (
    output imemReq, imemAddr, dmemRead, dmemWrite, dmemAddr, dmemWdata, dmemBe,
    output memReady, memRespValid, memRdata,
    input  imemRdata, dmemRdata, memValid, memWe, memAddr, memWdata, memBe, memStall
  );
endinterface

// File: rtl/mem_resp_buffer.sv
// Capture registers for fetched instruction and load data, plus the per-cycle
// done flags that tell the arbiter which transactions already completed.
import mem_arbiter_pkg::*;

module mem_resp_buffer #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              capD,
  input  logic              capI,
  input  logic              clrDone,
  input  logic              wordSel,
  input  logic [DATA_W-1:0] memRdata,
  output logic              doneD,
  output logic              doneI,
  output logic [31:0]       instr,
  output logic [DATA_W-1:0] data
);

  logic [31:0] instrWord;

  // On a wide bus the fetch address picks which 32-bit half holds the instruction
  if (DATA_W >= 64) begin : gWordSel
    assign instrWord = wordSel ? memRdata[63:32] : memRdata[31:0];
  end else begin : gNoWordSel
    assign instrWord = memRdata[31:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      doneD <= 1'b0;
      doneI <= 1'b0;
      instr <= NopInstr;
      data  <= '0;
    end else begin
      if (clrDone) begin
        doneD <= 1'b0;
        doneI <= 1'b0;
      end else begin
        if (capD) doneD <= 1'b1;
        if (capI) doneI <= 1'b1;
      end
      if (capD) data  <= memRdata;
      if (capI) instr <= instrWord;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one shared memory port between the fetch and memory stages,
// serving data before instruction and stalling the pipeline until both finish.
import mem_arbiter_pkg::*;

module mem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.master bus
);

  localparam int BE_W = DATA_W / 8;

  memArbState_e      state;
  logic              needD, needI, doneD, doneI;
  logic              pendD, pendI, issueD, issueI;
  logic              capD, capI, stall;
  logic [ADDR_W-1:0] reqAddr;

  assign needD = bus.dmemRead | bus.dmemWrite;
  assign needI = bus.imemReq;
  assign pendD = needD & ~doneD;
  assign pendI = needI & ~doneI;
  assign stall = rst_n & (pendD | pendI);

  // IDLE presents the request in the cycle the need appears; DREQ/IREQ hold it
  assign issueD = rst_n & ((state == DREQ) | ((state == IDLE) & pendD));
  assign issueI = rst_n & ((state == IREQ) | ((state == IDLE) & ~pendD & pendI));

  assign capD    = (state == DRESP) & bus.memRespValid;
  assign capI    = (state == IRESP) & bus.memRespValid;
  assign reqAddr = issueD ? bus.dmemAddr : bus.imemAddr;

  always_comb begin
    bus.memValid = issueD | issueI;
    bus.memWe    = issueD & bus.dmemWrite;
    bus.memAddr  = reqAddr;
    bus.memWdata = bus.dmemWdata;
    bus.memBe    = issueD ? bus.dmemBe : {BE_W{1'b1}};
    bus.memStall = stall;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (issueD)      state <= bus.memReady ? DRESP : DREQ;
          else if (issueI) state <= bus.memReady ? IRESP : IREQ;
        end
        DREQ:  if (bus.memReady)     state <= DRESP;
        DRESP: if (bus.memRespValid) state <= needI ? IREQ : IDLE;
        IREQ:  if (bus.memReady)     state <= IRESP;
        IRESP: if (bus.memRespValid) state <= IDLE;
        default:                     state <= IDLE;
      endcase
    end
  end

  mem_resp_buffer #(.DATA_W(DATA_W)) uRespBuf (
    .clk      (clk),
    .rst_n    (rst_n),
    .capD     (capD),
    .capI     (capI),
    .clrDone  (~stall),
    .wordSel  (bus.imemAddr[2]),
    .memRdata (bus.memRdata),
    .doneD    (doneD),
    .doneI    (doneI),
    .instr    (bus.imemRdata),
    .data     (bus.dmemRdata)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed pipeline cycles, a 1-cycle
// memory model with optional backpressure, and a monitor checking requests and releases.
module tb_mem_arbiter;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;

  typedef struct {
    logic                we;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] be;
  } req_t;

  typedef struct {
    int                stalls;
    logic [31:0]       instr;
    logic [DATA_W-1:0] data;
    bit                chkI;
    bit                chkD;
  } ret_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   holdCnt = 0;

  req_t              reqQ[$];
  logic [DATA_W-1:0] respQ[$];
  ret_t              retQ[$];

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pushReq(input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata, input logic [7:0] be);
    req_t r;
    r.we = we; r.addr = addr; r.wdata = wdata; r.be = be;
    reqQ.push_back(r);
  endtask

  task automatic expectCycle(input int stalls, input logic [31:0] instr,
                             input logic [DATA_W-1:0] data, input bit chkI, input bit chkD);
    ret_t e;
    e.stalls = stalls; e.instr = instr; e.data = data; e.chkI = chkI; e.chkD = chkD;
    retQ.push_back(e);
  endtask

  task automatic setReq(input logic rd, input logic wr, input logic [63:0] dAddr,
                        input logic [63:0] dWdata, input logic [7:0] be,
                        input logic ir, input logic [63:0] iAddr);
    bus.dmemRead  = rd;
    bus.dmemWrite = wr;
    bus.dmemAddr  = dAddr;
    bus.dmemWdata = dWdata;
    bus.dmemBe    = be;
    bus.imemReq   = ir;
    bus.imemAddr  = iAddr;
  endtask

  // Wait for the stall to drop, then step past the edge that advances the pipeline
  task automatic waitRelease();
    bit got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk); #3;
      if (!bus.memStall) got = 1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL release_timeout: memStall still %b after 40 cycles", bus.memStall);
    end
    @(posedge clk); #1;
  endtask

  task automatic idleCycles(input int n);
    setReq(0, 0, 0, 0, 0, 0, 0);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Memory model: ready unless holdCnt asks for backpressure, response one cycle after accept
  initial begin : memModel
    logic              respPending;
    logic [DATA_W-1:0] respData;
    respPending = 1'b0;
    respData = '0;
    bus.memReady = 1'b1;
    bus.memRespValid = 1'b0;
    bus.memRdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        respPending = 1'b0;
        bus.memRespValid = 1'b0;
        bus.memReady = 1'b1;
      end else begin
        bus.memRespValid = respPending;
        bus.memRdata = respData;
        if (bus.memValid && holdCnt > 0) begin
          bus.memReady = 1'b0;
          holdCnt--;
        end else begin
          bus.memReady = 1'b1;
        end
        respPending = bus.memValid && bus.memReady;
        if (respPending) respData = (respQ.size() > 0) ? respQ.pop_front() : '0;
      end
    end
  end

  initial begin : monitor
    int   stallCnt;
    bit   waiting;
    logic need;
    req_t r;
    ret_t e;
    stallCnt = 0;
    waiting = 0;
    forever begin
      @(negedge clk); #2;
      if (!rst_n) begin
        stallCnt = 0;
        waiting = 0;
      end else begin
        need = bus.dmemRead | bus.dmemWrite | bus.imemReq;
        if (waiting) chk("valid_held", {63'd0, bus.memValid}, 64'd1);
        if (bus.memValid && !bus.memReady) begin
          waiting = 1;
          if (reqQ.size() == 0) chk("held_unexpected_req", 64'd1, 64'd0);
          else chk("held_addr", bus.memAddr, reqQ[0].addr);
        end else begin
          waiting = 0;
        end
        if (bus.memValid && bus.memReady) begin
          if (reqQ.size() == 0) begin
            chk("unexpected_req_addr", bus.memAddr, 64'd0);
          end else begin
            r = reqQ.pop_front();
            chk("req_we", {63'd0, bus.memWe}, {63'd0, r.we});
            chk("req_addr", bus.memAddr, r.addr);
            chk("req_be", {56'd0, bus.memBe}, {56'd0, r.be});
            if (r.we) chk("req_wdata", bus.memWdata, r.wdata);
          end
        end
        if (need) begin
          if (bus.memStall) begin
            stallCnt++;
          end else if (retQ.size() == 0) begin
            chk("unexpected_release", 64'd1, 64'd0);
            stallCnt = 0;
          end else begin
            e = retQ.pop_front();
            chk("stall_cycles", 64'(stallCnt), 64'(e.stalls));
            if (e.chkI) chk("imemRdata", {32'd0, bus.imemRdata}, {32'd0, e.instr});
            if (e.chkD) chk("dmemRdata", bus.dmemRdata, e.data);
            stallCnt = 0;
          end
        end else begin
          chk("idle_valid_stall", {62'd0, bus.memValid, bus.memStall}, 64'd0);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    setReq(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_memValid", {63'd0, bus.memValid}, 64'd0);
    chk("reset_memStall", {63'd0, bus.memStall}, 64'd0);
    chk("reset_imemRdata", {32'd0, bus.imemRdata}, 64'h13);
    chk("reset_dmemRdata", bus.dmemRdata, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Fetch only
    pushReq(0, 64'h100, 0, 8'hFF);
    respQ.push_back(64'h00000000_00500093);
    expectCycle(2, 32'h00500093, 0, 1, 0);
    setReq(0, 0, 0, 0, 0, 1, 64'h100);
    waitRelease();

    idleCycles(4);

    // Load then fetch of the upper word
    pushReq(0, 64'h2000, 0, 8'hFF);
    pushReq(0, 64'h104, 0, 8'hFF);
    respQ.push_back(64'h00000000_DEADBEEF);
    respQ.push_back(64'h00A00113_12345678);
    expectCycle(4, 32'h00A00113, 64'h00000000_DEADBEEF, 1, 1);
    setReq(1, 0, 64'h2000, 0, 8'hFF, 1, 64'h104);
    waitRelease();

    // Load with three cycles of memReady low, then fetch
    holdCnt = 3;
    pushReq(0, 64'h2010, 0, 8'hFF);
    pushReq(0, 64'h108, 0, 8'hFF);
    respQ.push_back(64'h01234567_89ABCDEF);
    respQ.push_back(64'hFFFFFFFF_00000033);
    expectCycle(7, 32'h00000033, 64'h01234567_89ABCDEF, 1, 1);
    setReq(1, 0, 64'h2010, 0, 8'hFF, 1, 64'h108);
    waitRelease();

    // Store with partial byte enables, then fetch
    pushReq(1, 64'h2008, 64'h11223344, 8'h0F);
    pushReq(0, 64'h10C, 0, 8'hFF);
    respQ.push_back(64'd0);
    respQ.push_back(64'h00100073_00000000);
    expectCycle(4, 32'h00100073, 0, 1, 0);
    setReq(0, 1, 64'h2008, 64'h11223344, 8'h0F, 1, 64'h10C);
    waitRelease();

    // Load with no fetch in the same cycle
    pushReq(0, 64'h2018, 0, 8'hFF);
    respQ.push_back(64'h55);
    expectCycle(2, 0, 64'h55, 0, 1);
    setReq(1, 0, 64'h2018, 0, 8'hFF, 0, 0);
    waitRelease();

    // Reset while the load response is pending, then restart the same cycle
    pushReq(0, 64'h3000, 0, 8'hFF);
    respQ.push_back(64'h5555);
    setReq(1, 0, 64'h3000, 0, 8'hFF, 1, 64'h110);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_memValid", {63'd0, bus.memValid}, 64'd0);
    chk("midreset_memStall", {63'd0, bus.memStall}, 64'd0);
    chk("midreset_imemRdata", {32'd0, bus.imemRdata}, 64'h13);
    chk("midreset_dmemRdata", bus.dmemRdata, 64'd0);
    reqQ.delete();
    respQ.delete();
    pushReq(0, 64'h3000, 0, 8'hFF);
    pushReq(0, 64'h110, 0, 8'hFF);
    respQ.push_back(64'hCAFEF00D_0BADF00D);
    respQ.push_back(64'h00000000_00200113);
    expectCycle(4, 32'h00200113, 64'hCAFEF00D_0BADF00D, 1, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    waitRelease();

    idleCycles(4);
    chk("queues_drained", 64'(reqQ.size() + respQ.size() + retQ.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
